irq_vec_ctrl: RTL and testbench

IRQ_VEC_CTRL -- requirements
Module: irq_vec_ctrl

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_prio_enc.sv | 37 +++
 rtl/irq_vec_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_irq_vec_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared opcode and state encodings for the interrupt vector controller,
// plus the vector address helper.
package irq_pkg;

    localparam logic [2:0] CMD_GETQ     = 3'd0;
    localparam logic [2:0] CMD_SETMASK  = 3'd1;
    localparam logic [2:0] CMD_SETMODE  = 3'd2;
    localparam logic [2:0] CMD_RETIRQ   = 3'd3;
    localparam logic [2:0] CMD_SETTIMER = 3'd4;
    localparam logic [2:0] CMD_WAITIRQ  = 3'd5;
    localparam logic [2:0] CMD_CLRPEND  = 3'd6;
    localparam logic [2:0] CMD_NOP      = 3'd7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PEND    = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;
    localparam logic [1:0] ST_WAIT    = 2'd3;

    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [4:0]  id,
                                             input int          shift);
        return base + ({27'd0, id} << shift);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible request vector.
module irq_prio_enc #(
    parameter int NIRQ = 32
) (
    input  logic [NIRQ-1:0] eligible,
    output logic            valid,
    output logic [4:0]      index
);

    logic [NIRQ-1:0] w_lower_any;
    logic [NIRQ-1:0] w_onehot;

    assign w_lower_any[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NIRQ; gi++) begin : g_lower
            assign w_lower_any[gi] = |eligible[gi-1:0];
        end
        for (gi = 0; gi < NIRQ; gi++) begin : g_onehot
            assign w_onehot[gi] = eligible[gi] & ~w_lower_any[gi];
        end
    endgenerate

    // w_onehot has at most one bit set, so OR-ing indices is safe
    always_comb begin
        index = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (w_onehot[i]) begin
                index = index | 5'(i);
            end
        end
    end

    assign valid = |eligible;

endmodule

// File: rtl/irq_vec_ctrl.sv
// Vectored interrupt controller: per-channel pend/mask/mode, a down-counting
// timer on channel 0, a 4-state request FSM and a small command port.
module irq_vec_ctrl
    import irq_pkg::*;
#(
    parameter int          NIRQ      = 32,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0010,
    parameter int          VEC_SHIFT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            cmd_valid,
    input  logic [2:0]      cmd,
    input  logic [31:0]     wdata,
    input  logic [31:0]     pc,
    input  logic            ack,
    output logic [31:0]     rdata,
    output logic            irq_req,
    output logic [31:0]     irq_vec,
    output logic [4:0]      irq_id,
    output logic [31:0]     pc_ret,
    output logic            waiting
);

    localparam logic [NIRQ-1:0] CH0 = NIRQ'(1);

    logic [1:0]      r_state;
    logic [NIRQ-1:0] r_pend;
    logic [NIRQ-1:0] r_mask;
    logic [NIRQ-1:0] r_mode;
    logic [NIRQ-1:0] r_sync;
    logic [NIRQ-1:0] r_prev;
    logic [31:0]     r_timer;
    logic [31:0]     r_pc_ret;
    logic [4:0]      r_id;

    logic [NIRQ-1:0] w_eligible;
    logic            w_win_valid;
    logic [4:0]      w_win_id;
    logic [NIRQ-1:0] w_hw_set;
    logic [NIRQ-1:0] w_set;
    logic [NIRQ-1:0] w_clr;
    logic [NIRQ-1:0] w_pend_next;
    logic [1:0]      w_state_next;
    logic            w_timer_fire;
    logic            w_take;
    logic            w_grant;

    logic w_cmd_setmask;
    logic w_cmd_setmode;
    logic w_cmd_settimer;
    logic w_cmd_clrpend;
    logic w_cmd_retirq;
    logic w_cmd_waitirq;

    assign w_cmd_setmask  = cmd_valid && (cmd == CMD_SETMASK);
    assign w_cmd_setmode  = cmd_valid && (cmd == CMD_SETMODE);
    assign w_cmd_settimer = cmd_valid && (cmd == CMD_SETTIMER);
    assign w_cmd_clrpend  = cmd_valid && (cmd == CMD_CLRPEND);
    assign w_cmd_retirq   = cmd_valid && (cmd == CMD_RETIRQ);
    assign w_cmd_waitirq  = cmd_valid && (cmd == CMD_WAITIRQ);

    assign w_eligible = r_pend & ~r_mask;

    irq_prio_enc #(
        .NIRQ (NIRQ)
    ) u_prio (
        .eligible (w_eligible),
        .valid    (w_win_valid),
        .index    (w_win_id)
    );

    assign w_timer_fire = (r_timer == 32'd1);

    // Set sources are OR-ed after the clear so a same-cycle set always wins
    assign w_set = w_hw_set | (w_timer_fire ? CH0 : '0);
    assign w_clr = (w_cmd_clrpend ? wdata[NIRQ-1:0] : '0)
                 | (w_take ? (CH0 << r_id) : '0);

    genvar gi;
    generate
        for (gi = 0; gi < NIRQ; gi++) begin : g_chan
            assign w_hw_set[gi]    = r_mode[gi] ? (r_sync[gi] & ~r_prev[gi]) : r_sync[gi];
            assign w_pend_next[gi] = w_set[gi] | (r_pend[gi] & ~w_clr[gi]);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_grant      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && w_win_valid) begin
                    w_state_next = ST_PEND;
                    w_grant      = 1'b1;
                end else if (w_cmd_waitirq) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_PEND: begin
                if (ack) begin
                    w_state_next = ST_SERVICE;
                    w_take       = 1'b1;
                end else if (!en) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (w_cmd_retirq) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (|r_pend) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pend   <= '0;
            r_mask   <= '1;
            r_mode   <= '1;
            r_sync   <= '0;
            r_prev   <= '0;
            r_timer  <= '0;
            r_pc_ret <= '0;
            r_id     <= '0;
        end else begin
            // Channel 0 is owned by the timer; its raw input is discarded here
            r_sync  <= irq_in & ~CH0;
            r_prev  <= r_sync;
            r_pend  <= w_pend_next;
            r_state <= w_state_next;
            if (w_cmd_setmask) begin
                r_mask <= wdata[NIRQ-1:0];
            end
            if (w_cmd_setmode) begin
                r_mode <= wdata[NIRQ-1:0];
            end
            if (w_cmd_settimer) begin
                r_timer <= wdata;
            end else if (r_timer != 32'd0) begin
                r_timer <= r_timer - 32'd1;
            end
            if (w_grant) begin
                r_id <= w_win_id;
            end
            if (w_take) begin
                r_pc_ret <= pc;
            end
        end
    end

    // WAIT exit reports the pend snapshot, taking precedence over any command result
    always_comb begin
        rdata = '0;
        if (rst) begin
            rdata = '0;
        end else if ((r_state == ST_WAIT) && (|r_pend)) begin
            rdata = 32'(r_pend);
        end else if (cmd_valid) begin
            case (cmd)
                CMD_GETQ:     rdata = 32'(r_pend);
                CMD_SETMASK:  rdata = 32'(r_mask);
                CMD_SETMODE:  rdata = 32'(r_mode);
                CMD_RETIRQ:   rdata = (r_state == ST_SERVICE) ? r_pc_ret : 32'd0;
                CMD_SETTIMER: rdata = r_timer;
                default:      rdata = '0;
            endcase
        end
    end

    assign irq_req = (r_state == ST_PEND);
    assign waiting = (r_state == ST_WAIT);
    assign irq_id  = r_id;
    assign irq_vec = vec_addr(VEC_BASE, r_id, VEC_SHIFT);
    assign pc_ret  = r_pc_ret;

endmodule

// File: tb/tb_irq_vec_ctrl.sv
// Bench for irq_vec_ctrl: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against a behavioural model.
module tb_irq_vec_ctrl;

    localparam logic [2:0] OP_GETQ     = 3'd0;
    localparam logic [2:0] OP_SETMASK  = 3'd1;
    localparam logic [2:0] OP_SETMODE  = 3'd2;
    localparam logic [2:0] OP_RETIRQ   = 3'd3;
    localparam logic [2:0] OP_SETTIMER = 3'd4;
    localparam logic [2:0] OP_WAITIRQ  = 3'd5;
    localparam logic [2:0] OP_CLRPEND  = 3'd6;
    localparam logic [2:0] OP_NOP      = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] irq_in = '0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd = OP_NOP;
    logic [31:0] wdata = '0;
    logic [31:0] pc = '0;
    logic        ack = 1'b0;
    logic [31:0] rdata;
    logic        irq_req;
    logic [31:0] irq_vec;
    logic [4:0]  irq_id;
    logic [31:0] pc_ret;
    logic        waiting;

    irq_vec_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .irq_in    (irq_in),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .wdata     (wdata),
        .pc        (pc),
        .ack       (ack),
        .rdata     (rdata),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_id    (irq_id),
        .pc_ret    (pc_ret),
        .waiting   (waiting)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] c_rdata;
    logic        c_req;
    logic [4:0]  c_id;
    logic [31:0] c_vec;
    logic        c_wait;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive just after the edge, sample on the falling edge.
    task automatic cyc(input logic cv, input logic [2:0] c, input logic [31:0] wd,
                       input logic [31:0] irq, input logic e, input logic a, input logic [31:0] p);
        cmd_valid = cv; cmd = c; wdata = wd; irq_in = irq; en = e; ack = a; pc = p;
        @(negedge clk);
        c_rdata = rdata; c_req = irq_req; c_id = irq_id; c_vec = irq_vec; c_wait = waiting;
        $display("txn cv=%0b cmd=%0d wdata=%08h irq=%08h en=%0b ack=%0b -> rdata=%08h req=%0b id=%0d vec=%08h wait=%0b",
                 cv, c, wd, irq, e, a, c_rdata, c_req, c_id, c_vec, c_wait);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd = OP_SETMASK; wdata = '0;
        en = 1'b0; ack = 1'b0; irq_in = '0; pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("reset rdata", rdata, 32'h0);
        check32("reset irq_req", 32'(irq_req), 32'h0);
        check32("reset irq_id", 32'(irq_id), 32'h0);
        check32("reset irq_vec", irq_vec, 32'h10);
        check32("reset waiting", 32'(waiting), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; cmd_valid = 1'b0; cmd = OP_NOP;
    endtask

    task automatic wait_req(input string name, input logic [31:0] irq, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            cyc(1'b0, OP_NOP, 32'h0, irq, 1'b1, 1'b0, 32'h0);
            if (c_req) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: irq_req stayed 0 for %0d cycles, want 1", name, budget);
        end
    endtask

    typedef struct {
        logic        cv;
        logic [2:0]  c;
        logic [31:0] wd;
        logic [31:0] irq;
        logic        a;
        logic [31:0] p;
        logic [31:0] x_rdata;
        logic        x_req;
        logic [4:0]  x_id;
        logic [31:0] x_vec;
        logic        x_wait;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input logic cv, input logic [2:0] c, input logic [31:0] wd,
                           input logic [31:0] irq, input logic a, input logic [31:0] p,
                           input logic [31:0] xr, input logic xq, input logic [4:0] xi,
                           input logic [31:0] xv, input logic xw);
        vec_t v;
        v.cv = cv; v.c = c; v.wd = wd; v.irq = irq; v.a = a; v.p = p;
        v.x_rdata = xr; v.x_req = xq; v.x_id = xi; v.x_vec = xv; v.x_wait = xw;
        tbl.push_back(v);
    endtask

    // Behavioural model, stated directly in terms of the channel rules
    typedef enum int {M_IDLE, M_PEND, M_SERV, M_WAIT} mst_t;
    mst_t        m_st;
    logic [31:0] m_pend, m_mask, m_mode, m_timer, m_pcret, m_sync, m_prev;
    int          m_id;

    task automatic m_reset();
        m_st = M_IDLE; m_pend = '0; m_mask = '1; m_mode = '1;
        m_timer = '0; m_pcret = '0; m_sync = '0; m_prev = '0; m_id = 0;
    endtask

    task automatic m_expect(output logic [31:0] xr, output logic xq, output logic [4:0] xi,
                            output logic [31:0] xv, output logic xw);
        xr = '0;
        if (!rst) begin
            if (m_st == M_WAIT && m_pend != 0) xr = m_pend;
            else if (cmd_valid) begin
                case (cmd)
                    OP_GETQ:     xr = m_pend;
                    OP_SETMASK:  xr = m_mask;
                    OP_SETMODE:  xr = m_mode;
                    OP_RETIRQ:   xr = (m_st == M_SERV) ? m_pcret : 32'h0;
                    OP_SETTIMER: xr = m_timer;
                    default:     xr = '0;
                endcase
            end
        end
        xq = (m_st == M_PEND);
        xi = 5'(m_id);
        xv = 32'h10 + 32'(m_id) * 32'd4;
        xw = (m_st == M_WAIT);
    endtask

    task automatic m_clock();
        logic [31:0] np;
        logic [31:0] elig;
        int          lo;
        if (rst) begin
            m_reset();
            return;
        end
        np = m_pend;
        if (cmd_valid && cmd == OP_CLRPEND) np = np & ~wdata;
        if (m_st == M_PEND && ack) np[m_id] = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (m_mode[i] ? (m_sync[i] && !m_prev[i]) : m_sync[i]) np[i] = 1'b1;
        end
        if (m_timer == 32'd1) np[0] = 1'b1;

        elig = m_pend & ~m_mask;
        lo = 0;
        for (int i = 31; i >= 0; i--) if (elig[i]) lo = i;
        case (m_st)
            M_IDLE: if (en && elig != 0) begin m_st = M_PEND; m_id = lo; end
                    else if (cmd_valid && cmd == OP_WAITIRQ) m_st = M_WAIT;
            M_PEND: if (ack) begin m_st = M_SERV; m_pcret = pc; end
                    else if (!en) m_st = M_IDLE;
            M_SERV: if (cmd_valid && cmd == OP_RETIRQ) m_st = M_IDLE;
            M_WAIT: if (m_pend != 0) m_st = M_IDLE;
            default: m_st = M_IDLE;
        endcase

        if (cmd_valid && cmd == OP_SETMASK) m_mask = wdata;
        if (cmd_valid && cmd == OP_SETMODE) m_mode = wdata;
        if (cmd_valid && cmd == OP_SETTIMER) m_timer = wdata;
        else if (m_timer != 0) m_timer = m_timer - 1;
        m_pend = np;
        m_prev = m_sync;
        m_sync = irq_in;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] xr, xv;
        logic        xq, xw;
        logic [4:0]  xi;

        // cv  cmd          wdata         irq       ack pc       | rdata        req id vec      wait
        add_row(1, OP_SETMASK,  32'h0,        32'h0,    0, 32'h0,   32'hFFFF_FFFF, 0, 0,  32'h10, 0);
        add_row(1, OP_SETMODE,  32'hFFFF_FFFF,32'h0,    0, 32'h0,   32'hFFFF_FFFF, 0, 0,  32'h10, 0);
        add_row(1, OP_GETQ,     32'h0,        32'h4,    0, 32'h0,   32'h0,         0, 0,  32'h10, 0);
        add_row(1, OP_NOP,      32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 0,  32'h10, 0);
        add_row(1, OP_GETQ,     32'h0,        32'h0,    0, 32'h0,   32'h4,         0, 0,  32'h10, 0);
        add_row(0, OP_NOP,      32'h0,        32'h0,    1, 32'h100, 32'h0,         1, 2,  32'h18, 0);
        add_row(1, OP_GETQ,     32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 2,  32'h18, 0);
        add_row(1, OP_RETIRQ,   32'h0,        32'h0,    0, 32'h0,   32'h100,       0, 2,  32'h18, 0);
        add_row(1, OP_RETIRQ,   32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 2,  32'h18, 0);
        add_row(0, OP_NOP,      32'h0,        32'h408,  0, 32'h0,   32'h0,         0, 2,  32'h18, 0);
        add_row(1, OP_GETQ,     32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 2,  32'h18, 0);
        add_row(1, OP_GETQ,     32'h0,        32'h0,    0, 32'h0,   32'h408,       0, 2,  32'h18, 0);
        add_row(0, OP_NOP,      32'h0,        32'h0,    1, 32'h200, 32'h0,         1, 3,  32'h1C, 0);
        add_row(1, OP_GETQ,     32'h0,        32'h0,    0, 32'h0,   32'h400,       0, 3,  32'h1C, 0);
        add_row(1, OP_RETIRQ,   32'h0,        32'h0,    0, 32'h0,   32'h200,       0, 3,  32'h1C, 0);
        add_row(0, OP_NOP,      32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 3,  32'h1C, 0);
        add_row(0, OP_NOP,      32'h0,        32'h0,    1, 32'h300, 32'h0,         1, 10, 32'h38, 0);
        add_row(1, OP_RETIRQ,   32'h0,        32'h0,    0, 32'h0,   32'h300,       0, 10, 32'h38, 0);
        add_row(1, OP_GETQ,     32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 10, 32'h38, 0);
        add_row(1, OP_SETTIMER, 32'h5,        32'h0,    0, 32'h0,   32'h0,         0, 10, 32'h38, 0);
        add_row(1, OP_WAITIRQ,  32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 10, 32'h38, 0);
        add_row(1, OP_WAITIRQ,  32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 10, 32'h38, 1);
        add_row(0, OP_NOP,      32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 10, 32'h38, 1);
        add_row(0, OP_NOP,      32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 10, 32'h38, 1);
        add_row(0, OP_NOP,      32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 10, 32'h38, 1);
        add_row(0, OP_NOP,      32'h0,        32'h0,    0, 32'h0,   32'h1,         0, 10, 32'h38, 1);
        add_row(0, OP_NOP,      32'h0,        32'h0,    0, 32'h0,   32'h0,         0, 10, 32'h38, 0);
        add_row(0, OP_NOP,      32'h0,        32'h0,    1, 32'h400, 32'h0,         1, 0,  32'h10, 0);
        add_row(1, OP_RETIRQ,   32'h0,        32'h0,    0, 32'h0,   32'h400,       0, 0,  32'h10, 0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].cv, tbl[i].c, tbl[i].wd, tbl[i].irq, 1'b1, tbl[i].a, tbl[i].p);
            check32($sformatf("row%0d rdata", i), c_rdata, tbl[i].x_rdata);
            check32($sformatf("row%0d irq_req", i), 32'(c_req), 32'(tbl[i].x_req));
            check32($sformatf("row%0d irq_id", i), 32'(c_id), 32'(tbl[i].x_id));
            check32($sformatf("row%0d irq_vec", i), c_vec, tbl[i].x_vec);
            check32($sformatf("row%0d waiting", i), 32'(c_wait), 32'(tbl[i].x_wait));
        end

        // Level request behind the mask, then unmasked; CLRPEND loses to a held level
        do_reset();
        cyc(1, OP_SETMASK, 32'h400, 32'h0, 1, 0, 0);
        check32("lvl setmask old", c_rdata, 32'hFFFF_FFFF);
        cyc(1, OP_SETMODE, 32'h0, 32'h0, 1, 0, 0);
        check32("lvl setmode old", c_rdata, 32'hFFFF_FFFF);
        repeat (3) cyc(0, OP_NOP, 32'h0, 32'h400, 1, 0, 0);
        cyc(1, OP_GETQ, 32'h0, 32'h400, 1, 0, 0);
        check32("lvl getq", c_rdata, 32'h400);
        check32("lvl masked req", 32'(c_req), 32'h0);
        cyc(1, OP_SETMASK, 32'h0, 32'h400, 1, 0, 0);
        check32("lvl setmask old2", c_rdata, 32'h400);
        wait_req("lvl unmask req", 32'h400, 6);
        check32("lvl id", 32'(c_id), 32'd10);
        cyc(0, OP_NOP, 32'h0, 32'h400, 1, 1, 32'h500);
        cyc(1, OP_CLRPEND, 32'h400, 32'h400, 1, 0, 0);
        cyc(1, OP_GETQ, 32'h0, 32'h400, 1, 0, 0);
        check32("set beats clrpend", c_rdata, 32'h400);
        cyc(1, OP_RETIRQ, 32'h0, 32'h400, 1, 0, 0);
        check32("lvl retirq", c_rdata, 32'h500);

        // SETTIMER landing on the expiry cycle
        do_reset();
        cyc(1, OP_SETTIMER, 32'd3, 32'h0, 1, 0, 0);
        check32("tmr first write", c_rdata, 32'h0);
        repeat (2) cyc(0, OP_NOP, 32'h0, 32'h0, 1, 0, 0);
        cyc(1, OP_SETTIMER, 32'd7, 32'h0, 1, 0, 0);
        check32("tmr old at expiry", c_rdata, 32'd1);
        cyc(1, OP_GETQ, 32'h0, 32'h0, 1, 0, 0);
        check32("tmr pend0 still set", c_rdata, 32'h1);
        cyc(1, OP_SETTIMER, 32'd0, 32'h0, 1, 0, 0);
        check32("tmr write won", c_rdata, 32'd6);

        // Dropping en while pending returns to IDLE; re-enabling re-requests
        do_reset();
        cyc(1, OP_SETMASK, 32'h0, 32'h0, 1, 0, 0);
        cyc(1, OP_SETTIMER, 32'd2, 32'h0, 1, 0, 0);
        wait_req("en timer req", 32'h0, 8);
        check32("en timer id", 32'(c_id), 32'd0);
        cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 0);
        cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 0);
        check32("en off req", 32'(c_req), 32'h0);
        cyc(0, OP_NOP, 32'h0, 32'h0, 1, 0, 0);
        cyc(0, OP_NOP, 32'h0, 32'h0, 1, 0, 0);
        check32("en back req", 32'(c_req), 32'h1);

        // Asynchronous reset in the middle of service
        do_reset();
        cyc(1, OP_SETMASK, 32'h0, 32'h0, 1, 0, 0);
        cyc(0, OP_NOP, 32'h0, 32'h20, 1, 0, 0);
        wait_req("svc req", 32'h0, 6);
        check32("svc id", 32'(c_id), 32'd5);
        cyc(0, OP_NOP, 32'h0, 32'h0, 1, 1, 32'h600);
        check32("svc pc_ret", pc_ret, 32'h600);
        cmd_valid = 1'b1; cmd = OP_SETMASK; wdata = 32'h0;
        #2;
        rst = 1'b1;
        #1;
        check32("rst mid rdata", rdata, 32'h0);
        check32("rst mid irq_req", 32'(irq_req), 32'h0);
        check32("rst mid irq_id", 32'(irq_id), 32'h0);
        check32("rst mid irq_vec", irq_vec, 32'h10);
        check32("rst mid waiting", 32'(waiting), 32'h0);
        check32("rst mid pc_ret", pc_ret, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, OP_SETMASK, 32'h0, 32'h0, 1, 0, 0);
        check32("post rst mask", c_rdata, 32'hFFFF_FFFF);
        cyc(1, OP_GETQ, 32'h0, 32'h0, 1, 0, 0);
        check32("post rst pend", c_rdata, 32'h0);
        check32("post rst req", 32'(c_req), 32'h0);

        // Randomized traffic against the model
        do_reset();
        m_reset();
        irq_in = '0;
        for (int k = 0; k < 1500; k++) begin
            rst       = ($urandom_range(0, 399) == 0);
            en        = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ (32'd1 << $urandom_range(0, 31));
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd       = 3'($urandom_range(0, 7));
            wdata     = (cmd == OP_SETTIMER) ? 32'($urandom_range(0, 12)) : $urandom;
            ack       = ($urandom_range(0, 4) < 2);
            pc        = $urandom;
            if (rst) m_reset();
            @(negedge clk);
            m_expect(xr, xq, xi, xv, xw);
            n_cmp++;
            if (rdata !== xr || irq_req !== xq || irq_id !== xi || irq_vec !== xv || waiting !== xw) begin
                n_fail++;
                $display("FAIL rnd cyc%0d: got rdata=%08h req=%0b id=%0d vec=%08h wait=%0b, want rdata=%08h req=%0b id=%0d vec=%08h wait=%0b",
                         k, rdata, irq_req, irq_id, irq_vec, waiting, xr, xq, xi, xv, xw);
            end
            if (cmd_valid) begin
                $display("txn rnd%0d cmd=%0d wdata=%08h -> rdata=%08h req=%0b id=%0d", k, cmd, wdata, rdata, irq_req, irq_id);
            end
            @(posedge clk);
            m_clock();
            #1;
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
